// File: rtl/prbs_checker.sv
// Self-synchronising checker for the XNOR-tap LFSR generator: locks onto the
// incoming serial stream, then counts checked bits and bit errors for BER.
module prbs_checker #(
  parameter int WIDTH  = 10,
  parameter int X1     = 6,
  parameter int X2     = 9,
  parameter int LOCK_N = 16,
  parameter int LOSS_N = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_N + 1);
  localparam int MISS_W  = $clog2(LOSS_N + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_N - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_N - 1);

  typedef enum logic [1:0] {SEED, CHECK, LOCKED} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   h_q, h_d, h_shift;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               locked_q, locked_d;
  logic               err_flag_q, err_flag_d;
  logic               pred, mis, cnt_bit, cnt_err;

  // Prediction is taken from the history before this bit is shifted in.
  assign pred    = h_q[X1] ~^ h_q[X2];
  assign mis     = in_bit != pred;
  assign h_shift = {h_q[WIDTH-2:0], in_bit};

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    fill_d     = fill_q;
    match_d    = match_q;
    miss_d     = miss_q;
    err_flag_d = 1'b0;
    cnt_bit    = 1'b0;
    cnt_err    = 1'b0;

    if (in_valid) begin
      h_d = h_shift;
      case (state_q)
        SEED: begin
          if (fill_q == FILL_LAST) begin
            state_d = CHECK;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        CHECK: begin
          if (mis) begin
            match_d = '0;
          end else if (match_q == MATCH_LAST) begin
            // All-ones is the XNOR lockup pattern (stuck-high line): never lock on it.
            match_d = '0;
            if (!(&h_shift)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        LOCKED: begin
          cnt_bit = 1'b1;
          if (mis) begin
            cnt_err    = 1'b1;
            err_flag_d = 1'b1;
            if (miss_q == MISS_LAST) begin
              state_d = SEED;
              fill_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
    end

    locked_d = (state_d == LOCKED);

    // Clear overrides any increment from a same-cycle bit; err_flag is unaffected.
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (cnt_bit && !(&bit_cnt_q)) bit_cnt_d = bit_cnt_q + CNT_W'(1);
      if (cnt_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SEED;
      h_q        <= '0;
      fill_q     <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      locked_q   <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      fill_q     <= fill_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      locked_q   <= locked_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign locked    = locked_q;
  assign err_flag  = err_flag_q;
  assign bit_count = bit_cnt_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, error triplets, clear, saturation,
// loss of lock, all-ones guard, idle gaps and asynchronous reset.
module tb_prbs_checker;
  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_bit, clear;
  logic        locked, err_flag, locked4, err_flag4;
  logic [15:0] bit_count, err_count;
  logic [3:0]  bit_count4, err_count4;
  logic [9:0]  g, ch;   // generator state, and history as the checker should hold it
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .locked(locked), .err_flag(err_flag), .bit_count(bit_count), .err_count(err_count)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .locked(locked4), .err_flag(err_flag4), .bit_count(bit_count4), .err_count(err_count4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic nxt(input logic [9:0] h);
    return h[6] ~^ h[9];
  endfunction

  task automatic send(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ch = {ch[8:0], b};
  endtask

  task automatic send_gen();
    logic b;
    b = nxt(g);
    g = {g[8:0], b};
    send(b);
  endtask

  task automatic send_miss();
    send(~nxt(ch));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    logic b;
    reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
    g = '0; ch = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst locked", locked, 0);
    chk("rst err_flag", err_flag, 0);
    chk("rst bit_count", bit_count, 0);
    chk("rst err_count", err_count, 0);
    reset_n = 1'b1;
    idle();

    // Lock after WIDTH + LOCK_N = 26 correct bits
    repeat (25) send_gen();
    chk("t1 before lock", locked, 0);
    send_gen();
    chk("t1 locked", locked, 1);
    chk("t1 err_count", err_count, 0);
    chk("t1 bit_count", bit_count, 0);

    // Single line error -> errors at offsets 0, 7, 10
    repeat (5) send_gen();
    chk("t2 bit_count5", bit_count, 5);
    b = nxt(g);
    g = {g[8:0], b};
    send(~b);
    chk("t2 flag0", err_flag, 1);
    chk("t2 err_count1", err_count, 1);
    for (int off = 1; off <= 10; off++) begin
      send_gen();
      chk($sformatf("t2 flag%0d", off), err_flag, (off == 7 || off == 10));
    end
    chk("t2 err_count3", err_count, 3);
    chk("t2 locked", locked, 1);
    chk("t2 bit_count16", bit_count, 16);
    chk("t2 bit_count4 sat", bit_count4, 15);
    chk("t2 err_count4", err_count4, 3);

    // Clear together with an errored bit
    send_miss();
    send_miss();
    chk("t4 err_count5", err_count, 5);
    clear = 1'b1;
    send_miss();
    clear = 1'b0;
    chk("t4 flag", err_flag, 1);
    chk("t4 err_count", err_count, 0);
    chk("t4 bit_count", bit_count, 0);
    chk("t4 err_count4", err_count4, 0);
    chk("t4 bit_count4", bit_count4, 0);
    chk("t4 locked", locked, 1);
    g = ch;
    send_gen();
    chk("t4 flag after", err_flag, 0);
    chk("t4 bit_count1", bit_count, 1);
    chk("t4 err_count0", err_count, 0);

    // Error runs of 7 keep lock; 4-bit err_count saturates at 15
    for (int r = 1; r <= 3; r++) begin
      repeat (7) send_miss();
      g = ch;
      send_gen();
      chk($sformatf("t5 err_count4 r%0d", r), err_count4, (7 * r > 15) ? 15 : 7 * r);
      chk($sformatf("t5 locked r%0d", r), locked, 1);
    end
    chk("t5 err_count", err_count, 21);
    chk("t5 bit_count", bit_count, 25);
    chk("t5 bit_count4", bit_count4, 15);

    // LOSS_N misses drop lock; then a stuck-high line must never lock
    repeat (7) send_miss();
    chk("t3 locked after 7", locked, 1);
    send_miss();
    chk("t3 locked after 8", locked, 0);
    chk("t3 flag8", err_flag, 1);
    chk("t3 err_count", err_count, 29);
    chk("t3 bit_count", bit_count, 33);
    nl = 0;
    repeat (100) begin
      send(1'b1);
      if (locked) nl++;
    end
    chk("t3 all-ones guard", nl, 0);
    chk("t3 bit_count held", bit_count, 33);
    chk("t3 err_count held", err_count, 29);
    chk("t3 err_count4 held", err_count4, 15);

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 rst bit_count", bit_count, 0);
    chk("t6 rst err_count", err_count, 0);
    chk("t6 rst err_count4", err_count4, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    g = '0; ch = '0;

    // Relock with idle gaps
    for (int i = 1; i <= 26; i++) begin
      repeat ($urandom_range(0, 2)) idle();
      send_gen();
      if (i == 25) chk("t6 gaps before lock", locked, 0);
    end
    chk("t6 gaps locked", locked, 1);
    send_miss();
    chk("t6 miss flag", err_flag, 1);
    idle();
    chk("t6 idle flag", err_flag, 0);
    chk("t6 idle err_count", err_count, 1);
    g = ch;
    send_gen();
    repeat (3) idle();
    chk("t6 idle bit_count", bit_count, 2);
    chk("t6 idle locked", locked, 1);

    // Reset while locked
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 rst2 locked", locked, 0);
    chk("t6 rst2 bit_count", bit_count, 0);
    chk("t6 rst2 err_count", err_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    g = '0; ch = '0;
    for (int i = 1; i <= 26; i++) begin
      repeat ($urandom_range(0, 1)) idle();
      send_gen();
      if (i == 25) chk("t6 relock before", locked, 0);
    end
    chk("t6 relock", locked, 1);
    chk("t6 relock4", locked4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
